// File: rtl/multdiv_unit_pkg.sv
// Shared encodings and FSM states for the iterative multiply/divide unit.
package multdiv_unit_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [4:0] OPCODE_RTYPE = 5'd0;
  localparam logic [4:0] ALU_OP_MUL   = 5'd6;
  localparam logic [4:0] ALU_OP_DIV   = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module multdiv_unit_div_step
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // quo_in doubles as the dividend shift register: its MSB feeds the remainder
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign ge      = (shifted >= {2'b00, divisor});
  assign diff    = shifted[WIDTH:0] - {1'b0, divisor};
  assign rem_out = ge ? diff : shifted[WIDTH:0];
  assign quo_out = {quo_in[WIDTH-2:0], ge};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: one bit per cycle on operand magnitudes,
// sign applied when the result is captured; busy stalls the pipeline meanwhile.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       rd_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [4:0]       rd_out,
  output logic             busy
);

  md_state_t state, state_nx;

  logic [WIDTH-1:0]   op_a_abs, op_b_abs;
  logic [WIDTH-1:0]   b_mag, quo, quo_nx, quo_signed;
  logic [WIDTH:0]     rem, rem_nx;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx, prod;
  logic [CNT_W-1:0]   count;
  logic [4:0]         rd_lat;
  logic               neg, last, mul_exc, div_exc;

  // Two's-complement negate maps 0x80000000 onto itself, which is the correct unsigned magnitude
  assign op_a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign op_b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign last   = (count == CNT_W'(WIDTH - 1));
  assign acc_nx = acc + (b_mag[0] ? mcand : '0);
  assign prod   = neg ? -acc_nx : acc_nx;
  assign mul_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));

  multdiv_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (b_mag),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  assign quo_signed = neg ? -quo_nx : quo_nx;
  // A positive quotient with the MSB set can only come from MIN / -1
  assign div_exc    = !neg && quo_nx[WIDTH-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      data_result    <= '0;
      data_exception <= 1'b0;
      rd_out         <= '0;
      b_mag          <= '0;
      neg            <= 1'b0;
      rd_lat         <= '0;
      acc            <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      count          <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            b_mag  <= op_b_abs;
            neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rd_lat <= rd_in;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op_a_abs};
            rem    <= '0;
            quo    <= op_a_abs;
            count  <= '0;
          end
        end
        MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          b_mag <= b_mag >> 1;
          count <= count + CNT_W'(1);
          if (last) begin
            data_result    <= prod[WIDTH-1:0];
            data_exception <= mul_exc;
            rd_out         <= rd_lat;
          end
        end
        DIV: begin
          if (b_mag == '0) begin
            data_result    <= '0;
            data_exception <= 1'b1;
            rd_out         <= rd_lat;
          end else begin
            rem   <= rem_nx;
            quo   <= quo_nx;
            count <= count + CNT_W'(1);
            if (last) begin
              data_result    <= quo_signed;
              data_exception <= div_exc;
              rd_out         <= rd_lat;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ctrl_MULT)     state_nx = MUL;
        else if (ctrl_DIV) state_nx = DIV;
      end
      MUL:     if (last) state_nx = DONE;
      DIV:     if (last || (b_mag == '0)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    data_resultRDY = (state == DONE);
  end

endmodule
